// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions the run/stop and clear pushbuttons, sequences the
// IDLE/RUN/PAUSE/CLEAR state machine and produces the counter's tick enable and
// one-cycle clear strobe. Everything runs on clk; reset is synchronous, active-low.
// Define LAP_HOLD_EN to add the lap button and the display hold output.

// Per-button conditioning: 2-FF synchronizer, stability debounce, and a
// one-cycle pulse on each accepted 0->1 transition (none on release).
module stopwatch_btn_cond #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The counter only advances while the synchronized input disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// State table:
//   state  | meaning
//   IDLE   | stopped, prescaler at 0, waiting for run or clear
//   RUN    | counting; prescaler advances and tick pulses every DIV cycles
//   PAUSE  | stopped, prescaler phase held for a seamless resume
//   CLEAR  | single-cycle state that drives the clr strobe, then IDLE
module stopwatch_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 10,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
`ifdef LAP_HOLD_EN
    input  logic       btn_lap,
    output logic       hold,
`endif
    output logic       tick,
    output logic       clr,
    output logic       running,
    output logic [1:0] state
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_CLEAR = 2'b11
    } state_t;

    state_t        cur;
    state_t        nxt;
    logic          p_run;
    logic          p_clr;
    logic [PW-1:0] presc;
    logic          tick_nxt;
    logic          clr_nxt;
    logic          running_nxt;

    stopwatch_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_run (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_run_stop),
        .press (p_run)
    );

    stopwatch_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_clr (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .press (p_clr)
    );

    assign state = cur;

    // State register plus the registered outputs, so clr and running line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur     <= S_IDLE;
            tick    <= 1'b0;
            clr     <= 1'b0;
            running <= 1'b0;
        end else begin
            cur     <= nxt;
            tick    <= tick_nxt;
            clr     <= clr_nxt;
            running <= running_nxt;
        end
    end

    // Next-state decode; clear wins over run where both are honoured, and RUN
    // ignores clear entirely.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: begin
                if (p_clr)      nxt = S_CLEAR;
                else if (p_run) nxt = S_RUN;
            end
            S_RUN: begin
                if (p_run) nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (p_clr)      nxt = S_CLEAR;
                else if (p_run) nxt = S_RUN;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Output decode; a tick due on the RUN->PAUSE edge is still issued because
    // it is qualified by the current state, not the next one.
    always_comb begin
        tick_nxt    = (cur == S_RUN) && (presc == DIV_LAST);
        clr_nxt     = (nxt == S_CLEAR);
        running_nxt = (nxt == S_RUN);
    end

    // Tick prescaler: free-runs in RUN, holds its phase in PAUSE, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
        end else begin
            case (cur)
                S_RUN:   presc <= (presc == DIV_LAST) ? '0 : presc + PW'(1);
                S_PAUSE: presc <= presc;
                default: presc <= '0;
            endcase
        end
    end

`ifdef LAP_HOLD_EN
    logic p_lap;

    stopwatch_btn_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_lap (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_lap),
        .press (p_lap)
    );

    // Lap toggles the display hold only while running; clearing releases it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold <= 1'b0;
        end else if (nxt == S_CLEAR) begin
            hold <= 1'b0;
        end else if ((cur == S_RUN) && p_lap) begin
            hold <= ~hold;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with CLK_HZ=100, TICK_HZ=10 (DIV=10), DEBOUNCE_CYC=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_run_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic       tick;
    logic       clr;
    logic       running;
    logic [1:0] state;
`ifdef LAP_HOLD_EN
    logic       hold;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(
        .CLK_HZ       (100),
        .TICK_HZ      (10),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
`ifdef LAP_HOLD_EN
        .btn_lap      (btn_lap),
        .hold         (hold),
`endif
        .tick         (tick),
        .clr          (clr),
        .running      (running),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       run;
        logic       clear;
        logic [1:0] exp_state;
        int         exp_clr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Hold the selected buttons for 10 cycles, release, let 12 more cycles settle.
    task automatic press(input logic r, input logic c, input logic l,
                         output int clr_seen, output int changes);
        logic [1:0] prev;
        clr_seen = 0;
        changes  = 0;
        prev     = state;
        btn_run_stop = r;
        btn_clear    = c;
        btn_lap      = l;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) begin
                btn_run_stop = 1'b0;
                btn_clear    = 1'b0;
                btn_lap      = 1'b0;
            end
            step();
            if (clr === 1'b1) clr_seen++;
            if (state !== prev) changes++;
            prev = state;
        end
    endtask

    function automatic logic [1:0] seq_state(input int k);
        if (k < 43)  return 2'd1;
        if (k < 153) return 2'd2;
        if (k < 180) return 2'd1;
        if (k < 207) return 2'd2;
        if (k < 240) return 2'd1;
        if (k < 267) return 2'd2;
        if (k == 267) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic seq_tick(input int k);
        if (k >= 1 && k <= 43)    return (k % 10) == 0;
        if (k >= 154 && k <= 180) return ((k - 150) % 10) == 0;
        if (k >= 208 && k <= 240) return ((k - 207) % 10) == 0;
        return 1'b0;
    endfunction

    initial begin
        int         cs;
        int         ch;
        int         cnt;
        logic [1:0] prev;

        vecs[0]  = '{1'b0, 1'b1, 2'd0, 1};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 0};
        vecs[3]  = '{1'b1, 1'b1, 2'd2, 0};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 0};
        vecs[5]  = '{1'b1, 1'b0, 2'd2, 0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 1};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, 1};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 0};
        vecs[9]  = '{1'b1, 1'b0, 2'd2, 0};
        vecs[10] = '{1'b0, 1'b1, 2'd0, 1};

        // Reset for 3 cycles, then 50 idle cycles with everything quiet.
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (state !== 2'd0 || tick !== 1'b0 || clr !== 1'b0 || running !== 1'b0) cnt++;
        end
        check("reset_idle_bad_cycles", 32'(cnt), 32'(0));
        check("reset_state", 32'(state), 32'(0));

        // FSM transition table.
        for (int v = 0; v < 11; v++) begin
            press(vecs[v].run, vecs[v].clear, 1'b0, cs, ch);
            check($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
            check($sformatf("vec%0d_running", v), 32'(running), 32'(vecs[v].exp_state == 2'd1));
            check($sformatf("vec%0d_clr_cycles", v), 32'(cs), 32'(vecs[v].exp_clr));
        end

        // Press latency and tick timing from IDLE.
        btn_run_stop = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s == 7) begin
                check("p_run_at_7", 32'(dut.p_run), 32'(1));
                check("state_before_run", 32'(state), 32'(0));
            end
        end
        check("state_run", 32'(state), 32'(1));
        check("running_run", 32'(running), 32'(1));

        // Run, pause (phase 3), resume, pause on a tick, resume, pause at phase 3, clear.
        for (int k = 1; k <= 275; k++) begin
            case (k)
                12, 56, 166, 193, 220, 253: btn_run_stop = 1'b0;
                36, 146, 173, 200, 233:     btn_run_stop = 1'b1;
                260:                        btn_clear = 1'b1;
                272:                        btn_clear = 1'b0;
                default: ;
            endcase
            step();
            check($sformatf("seq_tick_k%0d", k), 32'(tick), 32'(seq_tick(k)));
            check($sformatf("seq_state_k%0d", k), 32'(state), 32'(seq_state(k)));
            check($sformatf("seq_running_k%0d", k), 32'(running), 32'(seq_state(k) == 2'd1));
            check($sformatf("seq_clr_k%0d", k), 32'(clr), 32'(k == 267));
            if (k == 266) check("presc_held_pause", 32'(dut.presc), 32'(3));
            if (k == 268) check("presc_zero_after_clear", 32'(dut.presc), 32'(0));
        end

        // Bounce: toggle every 2 cycles for 30 cycles, then hold high.
        prev = state;
        ch   = 0;
        for (int j = 0; j < 30; j++) begin
            btn_run_stop = ((j / 2) % 2) == 0;
            step();
            if (state !== prev) ch++;
            prev = state;
        end
        check("bounce_no_change_while_toggling", 32'(ch), 32'(0));
        btn_run_stop = 1'b1;
        for (int j = 0; j < 35; j++) begin
            if (j == 20) btn_run_stop = 1'b0;
            step();
            if (state !== prev) ch++;
            prev = state;
        end
        check("bounce_one_change", 32'(ch), 32'(1));
        check("bounce_state_run", 32'(state), 32'(1));

        // A 3-cycle glitch is shorter than the debounce window.
        ch = 0;
        btn_run_stop = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j == 3) btn_run_stop = 1'b0;
            step();
            if (state !== prev) ch++;
            prev = state;
        end
        check("glitch_no_change", 32'(ch), 32'(0));

        // Reset in the middle of RUN: everything back to idle, no clr strobe.
        rst = 1'b0;
        step();
        check("midrst_state", 32'(state), 32'(0));
        check("midrst_running", 32'(running), 32'(0));
        check("midrst_clr", 32'(clr), 32'(0));
        rst = 1'b1;
        cnt = 0;
        for (int j = 0; j < 12; j++) begin
            step();
            if (clr === 1'b1 || tick === 1'b1) cnt++;
        end
        check("midrst_quiet", 32'(cnt), 32'(0));
        check("midrst_presc", 32'(dut.presc), 32'(0));

`ifdef LAP_HOLD_EN
        press(1'b0, 1'b0, 1'b1, cs, ch);
        check("lap_idle_ignored", 32'(hold), 32'(0));
        press(1'b1, 1'b0, 1'b0, cs, ch);
        check("lap_state_run", 32'(state), 32'(1));
        press(1'b0, 1'b0, 1'b1, cs, ch);
        check("lap_hold_set", 32'(hold), 32'(1));
        cnt = 0;
        for (int j = 0; j < 30; j++) begin
            step();
            if (tick === 1'b1) cnt++;
        end
        check("lap_ticks_continue", 32'(cnt), 32'(3));
        press(1'b0, 1'b0, 1'b1, cs, ch);
        check("lap_hold_cleared", 32'(hold), 32'(0));
        press(1'b0, 1'b0, 1'b1, cs, ch);
        check("lap_hold_set_again", 32'(hold), 32'(1));
        press(1'b1, 1'b0, 1'b0, cs, ch);
        check("lap_state_pause", 32'(state), 32'(2));
        press(1'b0, 1'b0, 1'b1, cs, ch);
        check("lap_pause_ignored", 32'(hold), 32'(1));
        press(1'b0, 1'b1, 1'b0, cs, ch);
        check("lap_clear_drops_hold", 32'(hold), 32'(0));
        check("lap_clear_state", 32'(state), 32'(0));
        check("lap_clear_pulse", 32'(cs), 32'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
